// File: rtl/depthwise_mram_arbiter_pkg.sv
// Shared types and constants for the depthwise MRAM port arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package depthwise_mram_pkg;

  // Write-port arbitration state: idle, or locked to one requester mid-burst
  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_LOCK0 = 2'd1,
    W_LOCK1 = 2'd2
  } wr_state_t;

  // Requester indices shared by both ports
  localparam int REQ_CONV = 0;
  localparam int REQ_CPU  = 1;

  // Byte-enable width for the 32-bit MRAM word
  localparam int BE_WIDTH = 4;

  // One-hot vector selecting requester idx
  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/depthwise_mram_arbiter_if.sv
// Requester-side bundle: write beats in, grants/errors out, reads in, tagged data out.
// Latency: wires only; grants combinational, read data one cycle after grant.
// Backpressure: requester holds req and payload until its grant bit is seen.
interface depthwise_mram_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  import depthwise_mram_pkg::*;

  logic [1:0]            wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr0;
  logic [ADDR_WIDTH-1:0] wr_addr1;
  logic [DATA_WIDTH-1:0] wr_data0;
  logic [DATA_WIDTH-1:0] wr_data1;
  logic [BE_WIDTH-1:0]   wr_be0;
  logic [BE_WIDTH-1:0]   wr_be1;
  logic [1:0]            wr_last;
  logic [1:0]            wr_gnt;
  logic [1:0]            wr_err;

  logic [1:0]            rd_req;
  logic [31:0]           rd_addr0;
  logic [31:0]           rd_addr1;
  logic [1:0]            rd_gnt;
  logic [1:0]            rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1, wr_be0, wr_be1, wr_last,
    output rd_req, rd_addr0, rd_addr1,
    input  wr_gnt, wr_err, rd_gnt, rd_valid, rd_data
  );

  modport slave (
    input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1, wr_be0, wr_be1, wr_last,
    input  rd_req, rd_addr0, rd_addr1,
    output wr_gnt, wr_err, rd_gnt, rd_valid, rd_data
  );

endinterface

// File: rtl/depthwise_mram_arbiter_rr_arb2.sv
// Two-input round-robin grant; ptr picks the winner when both request.
// Latency: combinational.
// Backpressure: the losing requester simply sees no grant this cycle.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Single requester wins outright; contention resolved by ptr
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/depthwise_mram_arbiter.sv
// Arbitrates two writers (burst-locked, watchdogged) and two readers (per-cycle RR) onto dual-port MRAM.
// Latency: writes committed at the accepting edge; read data/tag valid the cycle after grant.
// Backpressure: ungranted requesters hold req/payload; a locked burst blocks the other writer.
module depthwise_mram_arbiter
  import depthwise_mram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  depthwise_mram_arbiter_if.slave bus,
  output logic                  mram_en_a,
  output logic [BE_WIDTH-1:0]   mram_we_a,
  output logic [ADDR_WIDTH-1:0] mram_addr_a,
  output logic [DATA_WIDTH-1:0] mram_din_a,
  output logic                  mram_en_b,
  output logic [31:0]           read_addr,
  input  logic [DATA_WIDTH-1:0] mram_dout_b
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  wr_state_t        wr_state;
  logic             wr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic [1:0]       wr_err_q;
  logic [1:0]       wr_arb_gnt;
  logic [1:0]       wr_gnt_int;
  logic             wr_accept;
  logic             wr_sel;
  logic             wr_sel_last;
  logic [CNT_W-1:0] next_cnt;

  logic             rd_ptr;
  logic [1:0]       rd_tag;
  logic [1:0]       rd_arb_gnt;
  logic [1:0]       rd_gnt_int;

  rr_arb2 u_wr_arb (
    .req (bus.wr_req),
    .ptr (wr_ptr),
    .gnt (wr_arb_gnt)
  );

  rr_arb2 u_rd_arb (
    .req (bus.rd_req),
    .ptr (rd_ptr),
    .gnt (rd_arb_gnt)
  );

  // Write grant: free arbitration when idle, pinned to the owner while locked,
  // and forced low during reset so nothing reaches the pins
  always_comb begin
    wr_gnt_int = 2'b00;
    case (wr_state)
      W_LOCK0: wr_gnt_int = 2'b01;
      W_LOCK1: wr_gnt_int = 2'b10;
      default: wr_gnt_int = wr_arb_gnt;
    endcase
    if (!resetn) wr_gnt_int = 2'b00;
  end

  // Accepted-beat decode and the beat count this beat would produce
  always_comb begin
    wr_accept   = |(bus.wr_req & wr_gnt_int);
    wr_sel      = wr_gnt_int[1];
    wr_sel_last = wr_sel ? bus.wr_last[1] : bus.wr_last[0];
    next_cnt    = (wr_state == W_IDLE) ? CNT_W'(1) : beat_cnt + 1'b1;
  end

  // Write FSM: lock on a non-final beat, release on last beat or when the
  // burst hits MAX_BURST (that beat still lands; wr_err flags the cut)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_state <= W_IDLE;
      wr_ptr   <= 1'b0;
      beat_cnt <= '0;
      wr_err_q <= 2'b00;
    end else begin
      wr_err_q <= 2'b00;
      if (wr_accept) begin
        if (wr_sel_last || (next_cnt == MAX_CNT)) begin
          wr_state <= W_IDLE;
          wr_ptr   <= ~wr_sel;
          beat_cnt <= '0;
          if (!wr_sel_last) wr_err_q <= req_onehot(wr_sel);
        end else begin
          wr_state <= wr_sel ? W_LOCK1 : W_LOCK0;
          beat_cnt <= next_cnt;
        end
      end
    end
  end

  // Port A pins driven straight from the accepted beat; idle lock cycles stay quiet
  always_comb begin
    mram_en_a   = wr_accept;
    mram_we_a   = '0;
    mram_addr_a = '0;
    mram_din_a  = '0;
    if (wr_accept) begin
      mram_we_a   = wr_sel ? bus.wr_be1   : bus.wr_be0;
      mram_addr_a = wr_sel ? bus.wr_addr1 : bus.wr_addr0;
      mram_din_a  = wr_sel ? bus.wr_data1 : bus.wr_data0;
    end
  end

  // Read grant and port B pins, suppressed during reset
  always_comb begin
    rd_gnt_int = resetn ? rd_arb_gnt : 2'b00;
    mram_en_b  = |rd_gnt_int;
    read_addr  = '0;
    if (rd_gnt_int[1])      read_addr = bus.rd_addr1;
    else if (rd_gnt_int[0]) read_addr = bus.rd_addr0;
  end

  // Read pointer flips on every contended cycle; tag follows the grant by one cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= 1'b0;
      rd_tag <= 2'b00;
    end else begin
      rd_tag <= rd_gnt_int;
      if (&bus.rd_req) rd_ptr <= ~rd_ptr;
    end
  end

  // Requester-facing outputs
  always_comb begin
    bus.wr_gnt   = wr_gnt_int;
    bus.wr_err   = wr_err_q;
    bus.rd_gnt   = rd_gnt_int;
    bus.rd_valid = rd_tag;
    bus.rd_data  = mram_dout_b;
  end

endmodule

// File: tb/tb_depthwise_mram_arbiter.sv
// Directed bench for depthwise_mram_arbiter with a small byte-enabled MRAM model.
module tb_depthwise_mram_arbiter;
  import depthwise_mram_pkg::*;

  logic clk;
  logic resetn;
  logic        mram_en_a;
  logic [3:0]  mram_we_a;
  logic [9:0]  mram_addr_a;
  logic [31:0] mram_din_a;
  logic        mram_en_b;
  logic [31:0] read_addr;
  logic [31:0] mram_dout_b;

  int tests = 0;
  int fails = 0;

  depthwise_mram_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

  depthwise_mram_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_BURST(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .mram_en_a   (mram_en_a),
    .mram_we_a   (mram_we_a),
    .mram_addr_a (mram_addr_a),
    .mram_din_a  (mram_din_a),
    .mram_en_b   (mram_en_b),
    .read_addr   (read_addr),
    .mram_dout_b (mram_dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MRAM model: byte-enabled write on port A, registered read on port B
  logic [31:0] mem [0:1023];
  logic [31:0] merged;
  always @(posedge clk) begin
    if (mram_en_a) begin
      merged = mem[mram_addr_a];
      for (int b = 0; b < 4; b++)
        if (mram_we_a[b]) merged[b*8 +: 8] = mram_din_a[b*8 +: 8];
      mem[mram_addr_a] <= merged;
    end
  end
  always @(posedge clk or negedge resetn) begin
    if (!resetn) mram_dout_b <= 32'd0;
    else if (mram_en_b) mram_dout_b <= mem[read_addr[9:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wr_req = 2'b00; bus.wr_last = 2'b00;
    bus.wr_addr0 = '0; bus.wr_addr1 = '0;
    bus.wr_data0 = '0; bus.wr_data1 = '0;
    bus.wr_be0 = 4'h0; bus.wr_be1 = 4'h0;
    bus.rd_req = 2'b00; bus.rd_addr0 = '0; bus.rd_addr1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [1:0] wr_req;
    logic [1:0] wr_last;
    logic [1:0] rd_req;
    logic [1:0] exp_wr_gnt;
    logic [1:0] exp_rd_gnt;
    logic [1:0] exp_rd_valid;
    logic       exp_en_a;
  } vec_t;

  vec_t vecs [8];
  logic [1:0] prev;
  logic [1:0] expg;
  int en_cnt;

  initial begin
    // Single-beat writes keep the FSM idle, so each row exercises both pointers
    vecs[0] = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    vecs[1] = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 1'b1};
    vecs[2] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b01, 1'b1};
    vecs[3] = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b01, 2'b10, 1'b1};
    vecs[4] = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b10, 2'b01, 1'b1};
    vecs[5] = '{2'b11, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 1'b1};
    vecs[6] = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 1'b0};
    vecs[7] = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 1'b1};

    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    resetn = 1'b0;
    idle_inputs();
    bus.wr_req = 2'b11;
    bus.rd_req = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_wr_gnt", bus.wr_gnt, 2'b00);
    chk("reset_rd_gnt", bus.rd_gnt, 2'b00);
    chk("reset_rd_valid", bus.rd_valid, 2'b00);
    chk("reset_wr_err", bus.wr_err, 2'b00);
    chk("reset_en_a", mram_en_a, 1'b0);
    chk("reset_en_b", mram_en_b, 1'b0);

    // Table: arbitration pointers on both ports
    do_reset();
    bus.wr_addr0 = 10'h3F0; bus.wr_addr1 = 10'h3F1;
    bus.wr_be0 = 4'hF; bus.wr_be1 = 4'hF;
    bus.rd_addr0 = 32'h3F0; bus.rd_addr1 = 32'h3F1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.wr_req  = vecs[i].wr_req;
      bus.wr_last = vecs[i].wr_last;
      bus.rd_req  = vecs[i].rd_req;
      #1;
      chk($sformatf("vec%0d_wr_gnt", i), bus.wr_gnt, vecs[i].exp_wr_gnt);
      chk($sformatf("vec%0d_rd_gnt", i), bus.rd_gnt, vecs[i].exp_rd_gnt);
      chk($sformatf("vec%0d_rd_valid", i), bus.rd_valid, vecs[i].exp_rd_valid);
      chk($sformatf("vec%0d_en_a", i), mram_en_a, vecs[i].exp_en_a);
    end

    // Single 4-beat burst from requester 0, then read back
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.wr_req = 2'b01;
      bus.wr_addr0 = 10'h10 + 10'(k);
      bus.wr_data0 = 32'hA0 + 32'(k);
      bus.wr_be0 = 4'hF;
      bus.wr_last = (k == 3) ? 2'b01 : 2'b00;
      #1;
      chk($sformatf("burst_gnt%0d", k), bus.wr_gnt, 2'b01);
      chk($sformatf("burst_en%0d", k), mram_en_a, 1'b1);
      chk($sformatf("burst_addr%0d", k), mram_addr_a, 10'h10 + 10'(k));
      chk($sformatf("burst_din%0d", k), mram_din_a, 32'hA0 + 32'(k));
    end
    @(negedge clk);
    bus.wr_req = 2'b00; bus.wr_last = 2'b00;
    bus.rd_req = 2'b01; bus.rd_addr0 = 32'h10;
    #1;
    chk("burst_post_en_a", mram_en_a, 1'b0);
    chk("rd0_gnt", bus.rd_gnt, 2'b01);
    chk("rd0_read_addr", read_addr, 32'h10);
    chk("rd0_valid_early", bus.rd_valid, 2'b00);
    @(negedge clk);
    bus.rd_req = 2'b00;
    #1;
    chk("rd0_valid", bus.rd_valid, 2'b01);
    chk("rd0_data", bus.rd_data, 32'hA0);

    // Burst lock: requester 1 waits through requester 0's 3-beat burst
    do_reset();
    bus.wr_addr1 = 10'h30; bus.wr_data1 = 32'hB1; bus.wr_be1 = 4'hF;
    bus.wr_addr0 = 10'h28; bus.wr_data0 = 32'hC0; bus.wr_be0 = 4'hF;
    @(negedge clk); bus.wr_req = 2'b11; bus.wr_last = 2'b10; #1;
    chk("lock_b1_gnt", bus.wr_gnt, 2'b01);
    @(negedge clk); bus.wr_req = 2'b10; #1;
    chk("lock_idle_gnt", bus.wr_gnt, 2'b01);
    chk("lock_idle_en", mram_en_a, 1'b0);
    @(negedge clk); bus.wr_req = 2'b11; bus.wr_addr0 = 10'h29; #1;
    chk("lock_b2_gnt", bus.wr_gnt, 2'b01);
    chk("lock_b2_addr", mram_addr_a, 10'h29);
    @(negedge clk); bus.wr_addr0 = 10'h2A; bus.wr_last = 2'b11; #1;
    chk("lock_b3_gnt", bus.wr_gnt, 2'b01);
    @(negedge clk); bus.wr_req = 2'b10; bus.wr_last = 2'b10; #1;
    chk("lock_req1_gnt", bus.wr_gnt, 2'b10);
    chk("lock_req1_addr", mram_addr_a, 10'h30);
    @(negedge clk); bus.wr_req = 2'b11; bus.wr_last = 2'b11; #1;
    chk("lock_ptr_back0", bus.wr_gnt, 2'b01);

    // Watchdog: requester 1 never sends last
    do_reset();
    en_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus.wr_req = 2'b10; bus.wr_last = 2'b00;
      bus.wr_addr1 = 10'h40 + 10'(k); bus.wr_data1 = 32'(k); bus.wr_be1 = 4'hF;
      #1;
      if (bus.wr_gnt !== 2'b10) chk($sformatf("wd_gnt%0d", k), bus.wr_gnt, 2'b10);
      if (bus.wr_err !== 2'b00) chk($sformatf("wd_err_early%0d", k), bus.wr_err, 2'b00);
      if (mram_en_a) en_cnt++;
    end
    chk("wd_beats_written", en_cnt, 16);
    @(negedge clk);
    bus.wr_req = 2'b11; bus.wr_last = 2'b01; bus.wr_addr1 = 10'h50;
    bus.wr_addr0 = 10'h60; bus.wr_be0 = 4'hF;
    #1;
    chk("wd_err_pulse", bus.wr_err, 2'b10);
    chk("wd_next_gnt", bus.wr_gnt, 2'b01);
    chk("wd_beat16_mem", mem[10'h4F], 32'd15);
    @(negedge clk);
    bus.wr_req = 2'b10; bus.wr_last = 2'b00;
    #1;
    chk("wd_err_clear", bus.wr_err, 2'b00);
    chk("wd_req1_again", bus.wr_gnt, 2'b10);

    // Read fairness: both readers request for 8 cycles
    do_reset();
    bus.rd_addr0 = 32'h10; bus.rd_addr1 = 32'h20;
    prev = 2'b00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.rd_req = 2'b11;
      #1;
      expg = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("rr_gnt%0d", k), bus.rd_gnt, expg);
      chk($sformatf("rr_valid%0d", k), bus.rd_valid, prev);
      chk($sformatf("rr_addr%0d", k), read_addr, (k % 2 == 0) ? 32'h10 : 32'h20);
      prev = expg;
    end
    @(negedge clk);
    bus.rd_req = 2'b00;
    #1;
    chk("rr_tail_valid", bus.rd_valid, 2'b10);
    chk("rr_tail_gnt", bus.rd_gnt, 2'b00);

    // Byte enables and the be=0 write
    do_reset();
    @(negedge clk);
    bus.wr_req = 2'b10; bus.wr_last = 2'b10; bus.wr_addr1 = 10'h60;
    bus.wr_data1 = 32'h11223344; bus.wr_be1 = 4'hF;
    #1;
    chk("be_full_we", mram_we_a, 4'hF);
    @(negedge clk); bus.wr_data1 = 32'hDEADBEEF; bus.wr_be1 = 4'h3; #1;
    chk("be_partial_we", mram_we_a, 4'h3);
    @(negedge clk); bus.wr_data1 = 32'hFFFFFFFF; bus.wr_be1 = 4'h0; #1;
    chk("be_zero_en", mram_en_a, 1'b1);
    chk("be_zero_we", mram_we_a, 4'h0);
    @(negedge clk);
    bus.wr_req = 2'b00; bus.rd_req = 2'b10; bus.rd_addr1 = 32'h60;
    #1;
    chk("be_rd_gnt", bus.rd_gnt, 2'b10);
    @(negedge clk); bus.rd_req = 2'b00; #1;
    chk("be_rd_valid", bus.rd_valid, 2'b10);
    chk("be_rd_data", bus.rd_data, 32'h1122BEEF);

    // Async reset during beat 2 of a burst
    do_reset();
    @(negedge clk);
    bus.wr_req = 2'b01; bus.wr_last = 2'b00; bus.wr_addr0 = 10'h70;
    bus.wr_data0 = 32'h55; bus.wr_be0 = 4'hF; bus.rd_req = 2'b11;
    #1;
    chk("arst_b1_gnt", bus.wr_gnt, 2'b01);
    @(negedge clk);
    bus.wr_addr0 = 10'h71;
    #1;
    chk("arst_b2_en", mram_en_a, 1'b1);
    #1 resetn = 1'b0;
    #1;
    chk("arst_wr_gnt", bus.wr_gnt, 2'b00);
    chk("arst_wr_err", bus.wr_err, 2'b00);
    chk("arst_rd_gnt", bus.rd_gnt, 2'b00);
    chk("arst_rd_valid", bus.rd_valid, 2'b00);
    chk("arst_en_a", mram_en_a, 1'b0);
    chk("arst_we_a", mram_we_a, 4'h0);
    chk("arst_addr_a", mram_addr_a, 10'h0);
    chk("arst_din_a", mram_din_a, 32'h0);
    chk("arst_en_b", mram_en_b, 1'b0);
    chk("arst_read_addr", read_addr, 32'h0);
    chk("arst_rd_data", bus.rd_data, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    bus.wr_req = 2'b10; bus.wr_last = 2'b10; bus.wr_addr1 = 10'h72;
    bus.wr_be1 = 4'hF; bus.rd_req = 2'b00;
    #1;
    chk("arst_new_gnt", bus.wr_gnt, 2'b10);
    chk("arst_new_en", mram_en_a, 1'b1);
    chk("arst_beat2_dropped", mem[10'h71], 32'h0);
    @(negedge clk);
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
